// File: rtl/dcache_perf_monitor_if.sv
// Handshake/observation bundle between the dcache/CPU side and the performance monitor.
interface dcache_perf_monitor_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned CYC_W = 16
);
  logic             start_i;
  logic             clear_i;
  logic             stall_i;
  logic             idle_i;
  logic             dirty_i;
  logic             read_i;
  logic             write_i;
  logic [2:0]       sel_i;
  logic [CNT_W-1:0] cnt_o;
  logic [CYC_W-1:0] cycle_o;
  logic             flush_o;
  logic             done_o;
  logic             ev_valid_o;
  logic [1:0]       ev_code_o;
  logic             ev_wb_o;

  // Driving side: the CPU/dcache environment.
  modport master (
    output start_i, clear_i, stall_i, idle_i, dirty_i, read_i, write_i, sel_i,
    input  cnt_o, cycle_o, flush_o, done_o, ev_valid_o, ev_code_o, ev_wb_o
  );

  // Observing side: the monitor itself.
  modport slave (
    input  start_i, clear_i, stall_i, idle_i, dirty_i, read_i, write_i, sel_i,
    output cnt_o, cycle_o, flush_o, done_o, ev_valid_o, ev_code_o, ev_wb_o
  );
endinterface

// File: rtl/dcache_perf_monitor.sv
// Data-cache access classifier with saturating event counters and a cycle budget
// that raises a one-shot flush request and then freezes all monitoring.
module dcache_perf_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned NUM_CYCLES = 200
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_perf_monitor_if.slave  mon
);

  localparam int unsigned NUM_CNT = 8;

  localparam logic [1:0] EV_RH = 2'd0;
  localparam logic [1:0] EV_RM = 2'd1;
  localparam logic [1:0] EV_WH = 2'd2;
  localparam logic [1:0] EV_WM = 2'd3;

  localparam int unsigned CNT_WB     = 4;
  localparam int unsigned CNT_STALL  = 5;
  localparam int unsigned CNT_TOTAL  = 6;
  localparam int unsigned CNT_MSTART = 7;

  localparam logic [CYC_W-1:0] BUDGET = CYC_W'(NUM_CYCLES);

  // Miss-tracking state: ST_MISS means the next unstalled access completes a miss.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_sel_q;
  logic [CYC_W-1:0]   cyc_q;
  logic               flush_q;
  logic               done_q;
  logic               ev_valid_q;
  logic [1:0]         ev_code_q;
  logic               ev_wb_q;

  logic               active_c;
  logic               ev_fire_c;
  logic [1:0]         ev_code_c;
  logic               wb_c;
  logic [NUM_CNT-1:0] inc_c;

  assign active_c = mon.start_i & ~done_q & ~mon.clear_i;

  // Miss-tracking state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Classification: next state, event strobe and per-counter increment requests.
  always_comb begin
    state_d   = state_q;
    ev_fire_c = 1'b0;
    ev_code_c = EV_RH;
    wb_c      = 1'b0;
    inc_c     = '0;

    if (mon.clear_i) begin
      state_d = ST_IDLE;
    end else if (active_c) begin
      if (mon.stall_i && mon.idle_i) begin
        state_d                = ST_MISS;
        inc_c[CNT_MSTART]      = 1'b1;
        inc_c[CNT_STALL]       = 1'b1;
        if (mon.write_i) begin
          ev_fire_c = 1'b1;
          ev_code_c = EV_WM;
        end else if (mon.read_i) begin
          ev_fire_c = 1'b1;
          ev_code_c = EV_RM;
        end
        wb_c = ev_fire_c & mon.dirty_i;
      end else if (!mon.stall_i) begin
        // The access that completes a miss was already counted as the miss.
        if (state_q == ST_IDLE) begin
          if (mon.write_i) begin
            ev_fire_c = 1'b1;
            ev_code_c = EV_WH;
          end else if (mon.read_i) begin
            ev_fire_c = 1'b1;
            ev_code_c = EV_RH;
          end
        end
        state_d = ST_IDLE;
      end else begin
        inc_c[CNT_STALL] = 1'b1;
      end

      if (ev_fire_c) begin
        inc_c[{1'b0, ev_code_c}] = 1'b1;
        inc_c[CNT_TOTAL]         = 1'b1;
      end
      if (wb_c) begin
        inc_c[CNT_WB] = 1'b1;
      end
    end
  end

  // Counters, cycle budget, event outputs and counter readout.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        cnt_q[i] <= '0;
      end
      cnt_sel_q  <= '0;
      cyc_q      <= '0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= 2'd0;
      ev_wb_q    <= 1'b0;
    end else if (mon.clear_i) begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        cnt_q[i] <= '0;
      end
      cnt_sel_q  <= '0;
      cyc_q      <= '0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= 2'd0;
      ev_wb_q    <= 1'b0;
    end else begin
      // Readout reflects the counter value before this edge's increment.
      cnt_sel_q  <= cnt_q[mon.sel_i];
      ev_valid_q <= ev_fire_c;
      ev_wb_q    <= wb_c;
      flush_q    <= 1'b0;
      if (ev_fire_c) begin
        ev_code_q <= ev_code_c;
      end
      if (active_c) begin
        for (int i = 0; i < int'(NUM_CNT); i++) begin
          if (inc_c[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
        cyc_q <= cyc_q + CYC_W'(1);
        if (cyc_q == BUDGET) begin
          flush_q <= 1'b1;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign mon.cnt_o      = cnt_sel_q;
  assign mon.cycle_o    = cyc_q;
  assign mon.flush_o    = flush_q;
  assign mon.done_o     = done_q;
  assign mon.ev_valid_o = ev_valid_q;
  assign mon.ev_code_o  = ev_code_q;
  assign mon.ev_wb_o    = ev_wb_q;

endmodule

// File: doc/dcache_perf_monitor.md
# dcache_perf_monitor

Synthesizable, parametrised successor to the bench-side data-cache hit/miss classifier and cycle-budget logic. It observes the dcache/CPU handshake every cycle and classifies each access as read hit, read miss, write hit or write miss, flagging write-backs. It keeps saturating event counters and a cycle budget that raises a one-shot flush request and then freezes. It sits beside `dcache` inside `CPU`, and its counters are readable through a select port.

## Interface
Parameters:
- `CNT_W`, 16: width of each event counter.
- `CYC_W`, 16: width of the cycle counter.
- `NUM_CYCLES`, 200: cycle budget. Must be < 2^CYC_W − 1.

Ports:
- `clk_i` in 1: clock; everything is on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-low.
- `start_i` in 1: monitoring enable.
- `clear_i` in 1: synchronous clear of all counters, state and outputs.
- `stall_i` in 1: dcache `cpu_stall_o`.
- `idle_i` in 1: high when dcache FSM state == 0.
- `dirty_i` in 1: dcache `sram_dirty` of the victim line.
- `read_i` in 1: CPU MemRead to dcache.
- `write_i` in 1: CPU MemWrite to dcache.
- `sel_i` in 3: counter select.
- `cnt_o` out CNT_W: registered value of the selected counter.
- `cycle_o` out CYC_W: enabled-cycle count.
- `flush_o` out 1: one-cycle flush request.
- `done_o` out 1: budget exhausted; monitoring frozen.
- `ev_valid_o` out 1: an event was classified in the previous cycle.
- `ev_code_o` out 2: event code; 0 = RH, 1 = RM, 2 = WH, 3 = WM.
- `ev_wb_o` out 1: the classified miss required a write-back.

## Operation
- Active cycle: `start_i` = 1 and `done_o` = 0. In any other cycle no counter, `flag` or `cycle_o` changes, and `ev_valid_o` goes to 0.
- Internal `flag` marks a miss in progress; its reset value is 0.
- Classification in each active cycle, in priority order:
  - **Miss start** (`stall_i` and `idle_i`): if `write_i`, WM; else if `read_i`, RM; else no event. If an event fires and `dirty_i` = 1, also count a write-back and set `ev_wb_o`. `flag` is set to 1 whether or not an event fired.
  - **Not stalled** (`stall_i` = 0): if `flag` = 0, then `write_i` gives WH, else `read_i` gives RH. The access that completes a miss is not re-counted as a hit. `flag` is cleared to 0.
  - **Stalled, not idle**: no event; `flag` is held.
- `write_i` has priority over `read_i` when both are high.
- Counter map for `sel_i`:
  - 0: RH
  - 1: RM
  - 2: WH
  - 3: WM
  - 4: write-backs
  - 5: stalled active cycles
  - 6: total accesses (hits + misses)
  - 7: miss-start cycles, including those with no access
- All counters saturate at all-ones and never wrap.
- Cycle budget:
  - `cycle_o` increments on every active cycle.
  - On the edge where an active cycle has `cycle_o` == NUM_CYCLES: `flush_o` <= 1 for exactly one cycle, `done_o` <= 1 and stays high, and `cycle_o` becomes NUM_CYCLES+1.
  - That cycle's access is still classified and counted.
- `clear_i` = 1 zeroes all counters, `flag`, `cycle_o`, `done_o`, `flush_o`, `ev_*` and `cnt_o`. It wins over a simultaneous event or budget expiry.
- Reset: every output and internal register is 0.

## Timing
- Classification happens in cycle N. Counters, `ev_*` and `cycle_o` update on edge N→N+1.
- `cnt_o` has one-cycle latency: the register captures `counter[sel_i]` as it was before that edge's update.
- `flush_o` and `done_o` rise on the same edge. `flush_o` falls on the next edge unless `rst_i` or `clear_i` intervene.
- `rst_i` asserted mid-operation clears state immediately, without waiting for a clock. Counting resumes on the first active edge after deassertion.
- `start_i` low freezes state, including mid-miss. `flag` is preserved, so the miss-completing access is still not double-counted.
- A miss lasting K cycles counts one miss plus K stalled cycles in counter 5; the completing cycle counts nothing further.

## Test plan
- **Reset**: `rst_i` = 0 mid-run with counters non-zero → all outputs read 0 asynchronously, before the next edge; `cnt_o` = 0 for every `sel_i`.
- **Read hit then write hit**: one `read_i` cycle and one `write_i` cycle, `stall_i` = 0 → `sel_i` 0 and 2 read 1; `ev_code_o` shows 0 then 2 one cycle later; counter 6 reads 2.
- **Dirty read miss**: `stall_i` = `idle_i` = `dirty_i` = `read_i` = 1 for 1 cycle, then `stall_i` = 1 with `idle_i` = 0 for 9 cycles, then `stall_i` = 0 with `read_i` = 1 → RM = 1, WB = 1, RH = 0, counter 5 = 10, `ev_wb_o` pulses once.
- **Read+write priority**: `read_i` = `write_i` = 1 with a clean miss start → WM = 1, RM = 0.
- **Budget** (NUM_CYCLES = 5): hold `start_i` = 1 with no accesses → `flush_o` high exactly one cycle, on the edge where `cycle_o` goes 5→6; `done_o` = 1 afterwards; further RH stimulus leaves counter 0 unchanged.
- **Saturation and clear** (CNT_W = 2): 5 RH events → counter 0 reads 3; then `clear_i` coincident with an RH event → counter 0 reads 0 and `ev_valid_o` = 0.
